apb4_regbus_bridge: RTL and testbench

Parametrised APB4 completer that converts APB transfers into a single-outstanding request/acknowledge register-bus transaction. It replaces the fixed 4-byte, no-strobe, always-ready slave used today. It adds:
- byte strobes
- stall back-pressure
- registered read data
- address range and alignment error detection
- a wait-state timeout

It sits between the SoC APB fabric and a generated register block.

---
 rtl/apb4_regbus_bridge.sv | 191 +++++++++++++++++++
 tb/tb_apb4_regbus_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_regbus_bridge.sv
// APB4 completer bridging to a single-outstanding register bus.
// Adds byte strobes, stall back-pressure, range/alignment errors and a wait timeout.
module apb4_regbus_bridge #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int TIMEOUT     = 16,
    parameter int ALIGN_CHECK = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic                    bus_req,
    output logic                    bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wr_data,
    output logic [DATA_WIDTH-1:0]   bus_wr_biten,
    input  logic                    bus_req_stall_wr,
    input  logic                    bus_req_stall_rd,
    input  logic                    bus_rd_ack,
    input  logic                    bus_rd_err,
    input  logic [DATA_WIDTH-1:0]   bus_rd_data,
    input  logic                    bus_wr_ack,
    input  logic                    bus_wr_err
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    // One past the last decoded byte; one extra bit so the compare never wraps.
    localparam logic [ADDR_WIDTH:0] LIMIT =
        (ADDR_WIDTH + 1)'(NUM_REGS * STRB_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_wr;
    logic [STRB_W-1:0]     r_strb;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_setup;
    logic                  w_oor;
    logic                  w_misalign;
    logic                  w_addr_bad;
    logic                  w_stall;
    logic                  w_ack;
    logic                  w_ack_err;
    logic [DATA_WIDTH-1:0] w_ack_data;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_tmo;
    logic                  w_in_req;
    logic                  w_in_resp;
    logic                  w_pready;
    logic [DATA_WIDTH-1:0] w_biten;

    // Setup-phase decode and address checks on the live APB inputs.
    always_comb begin
        w_setup    = psel && !penable;
        w_oor      = {1'b0, paddr} >= LIMIT;
        w_misalign = (ALIGN_CHECK != 0) &&
                     ((paddr % ADDR_WIDTH'(STRB_W)) != '0);
        w_addr_bad = w_oor || w_misalign;
    end

    // Select stall/ack/err lines matching the captured direction.
    always_comb begin
        w_stall    = r_wr ? bus_req_stall_wr : bus_req_stall_rd;
        w_ack      = r_wr ? bus_wr_ack : bus_rd_ack;
        w_ack_err  = r_wr ? bus_wr_err : bus_rd_err;
        w_ack_data = r_wr ? '0 : bus_rd_data;
    end

    // Wait-state timeout fires on the cycle the count would reach TIMEOUT.
    always_comb begin
        w_cnt_nxt = r_cnt + 1'b1;
        w_tmo     = (TIMEOUT != 0) && (w_cnt_nxt == CNT_W'(TIMEOUT));
    end

    // Expand byte strobes into per-bit enables.
    always_comb begin
        w_biten = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_biten[i] = r_strb[i/8];
        end
    end

    // State decode shared by the output drivers.
    always_comb begin
        w_in_req  = (r_state == S_REQ);
        w_in_resp = (r_state == S_RESP);
        w_pready  = w_in_resp && psel && penable;
    end

    // Main transfer FSM with capture, response and timeout registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_strb  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_setup) begin
                        r_addr  <= paddr;
                        r_wdata <= pwdata;
                        r_wr    <= pwrite;
                        r_strb  <= pwrite ? pstrb : '0;
                        r_rdata <= '0;
                        r_cnt   <= '0;
                        if (w_addr_bad) begin
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (!w_stall) begin
                        if (w_ack) begin
                            r_err   <= w_ack_err;
                            r_rdata <= w_ack_data;
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_ack) begin
                        r_err   <= w_ack_err;
                        r_rdata <= w_ack_data;
                        r_state <= S_RESP;
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    // A dropped psel abandons the response as well.
                    if (w_pready || !psel) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Register-bus request outputs, held at zero outside REQ.
    always_comb begin
        bus_req       = w_in_req;
        bus_req_is_wr = w_in_req && r_wr;
        bus_addr      = w_in_req ? r_addr : '0;
        bus_wr_data   = w_in_req ? r_wdata : '0;
        bus_wr_biten  = (w_in_req && r_wr) ? w_biten : '0;
    end

    // APB response outputs, only non-zero while completing in RESP.
    always_comb begin
        pready  = w_pready;
        pslverr = w_pready && r_err;
        prdata  = (w_pready && !r_wr) ? r_rdata : '0;
    end

endmodule

// File: tb/tb_apb4_regbus_bridge.sv
// Directed bench for apb4_regbus_bridge with an expected-response queue.
// A cycle-stepped bus responder injects stalls, delayed acks and stray acks.
module tb_apb4_regbus_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        bus_req;
    logic        bus_req_is_wr;
    logic [11:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_wr_biten;
    logic        bus_req_stall_wr = 1'b0;
    logic        bus_req_stall_rd = 1'b0;
    logic        bus_rd_ack = 1'b0;
    logic        bus_rd_err = 1'b0;
    logic [31:0] bus_rd_data = '0;
    logic        bus_wr_ack = 1'b0;
    logic        bus_wr_err = 1'b0;

    apb4_regbus_bridge dut (
        .clk              (clk),
        .rst              (rst),
        .psel             (psel),
        .penable          (penable),
        .pwrite           (pwrite),
        .paddr            (paddr),
        .pwdata           (pwdata),
        .pstrb            (pstrb),
        .prdata           (prdata),
        .pready           (pready),
        .pslverr          (pslverr),
        .bus_req          (bus_req),
        .bus_req_is_wr    (bus_req_is_wr),
        .bus_addr         (bus_addr),
        .bus_wr_data      (bus_wr_data),
        .bus_wr_biten     (bus_wr_biten),
        .bus_req_stall_wr (bus_req_stall_wr),
        .bus_req_stall_rd (bus_req_stall_rd),
        .bus_rd_ack       (bus_rd_ack),
        .bus_rd_err       (bus_rd_err),
        .bus_rd_data      (bus_rd_data),
        .bus_wr_ack       (bus_wr_ack),
        .bus_wr_err       (bus_wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_bus();
        bus_req_stall_wr = 1'b0;
        bus_req_stall_rd = 1'b0;
        bus_rd_ack       = 1'b0;
        bus_rd_err       = 1'b0;
        bus_rd_data      = '0;
        bus_wr_ack       = 1'b0;
        bus_wr_err       = 1'b0;
    endtask

    task automatic drive_ack(input logic wr, input logic er,
                             input logic [31:0] rd);
        if (wr) begin
            bus_wr_ack = 1'b1;
            bus_wr_err = er;
        end else begin
            bus_rd_ack  = 1'b1;
            bus_rd_err  = er;
            bus_rd_data = rd;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"},
            {28'b0, bus_req, pready, pslverr, bus_req_is_wr}, 32'h0);
        chk({tag, "_data"},
            prdata | bus_wr_data | bus_wr_biten | {20'b0, bus_addr}, 32'h0);
    endtask

    // One APB transfer; expected response pushed at setup, popped on pready.
    task automatic xfer(input string tag, input logic wr,
                        input logic [11:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input int stall,
                        input int ackd, input logic [31:0] rd,
                        input logic er, input bit noack,
                        input logic [31:0] ebiten, input logic eerr,
                        input logic [31:0] erdata, input int elat,
                        input int ereq);
        exp_t e;
        int   n = 0;
        int   reqc = 0;
        int   s = stall;
        int   d = -1;
        bit   acc = 1'b0;
        bit   acked = 1'b0;
        bit   done = 1'b0;
        @(negedge clk);
        clear_bus();
        psel = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = a;
        pwdata = wd;
        pstrb = st;
        e.rdata = erdata;
        e.err = eerr;
        e.lat = elat;
        sb.push_back(e);
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            penable = 1'b1;
            clear_bus();
            if (bus_req) begin
                reqc++;
                if (reqc == 1) begin
                    chk({tag, "_addr"}, {20'b0, bus_addr}, {20'b0, a});
                    chk({tag, "_iswr"}, {31'b0, bus_req_is_wr}, {31'b0, wr});
                    chk({tag, "_wdata"}, bus_wr_data, wd);
                    chk({tag, "_biten"}, bus_wr_biten, ebiten);
                end
                if (s > 0) begin
                    s--;
                    if (wr) bus_req_stall_wr = 1'b1;
                    else bus_req_stall_rd = 1'b1;
                    drive_ack(wr, 1'b1, 32'hBAD0BAD0);
                end else begin
                    acc = 1'b1;
                    if (wr) bus_req_stall_rd = 1'b1;
                    else bus_req_stall_wr = 1'b1;
                    if (!noack && ackd == 0) begin
                        drive_ack(wr, er, rd);
                        acked = 1'b1;
                    end else begin
                        d = ackd;
                    end
                end
            end else if (acc && !acked) begin
                d--;
                if (!noack && d == 0) begin
                    drive_ack(wr, er, rd);
                    acked = 1'b1;
                end else begin
                    drive_ack(!wr, 1'b1, 32'hBAD0BAD0);
                end
            end
            #1;
            if (pready) begin
                done = 1'b1;
                chk({tag, "_sb_avail"}, {31'b0, sb.size() != 0}, 32'h1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk({tag, "_prdata"}, prdata, e.rdata);
                    chk({tag, "_pslverr"}, {31'b0, pslverr}, {31'b0, e.err});
                    chk({tag, "_latency"}, n, e.lat);
                end
            end else begin
                chk({tag, "_quiet"}, prdata | {31'b0, pslverr}, 32'h0);
            end
        end
        chk({tag, "_completed"}, {31'b0, done}, 32'h1);
        chk({tag, "_reqcycles"}, reqc, ereq);
    endtask

    task automatic idle_cycle(input string tag, input bit stray_rd);
        @(negedge clk);
        psel = 1'b0;
        penable = 1'b0;
        clear_bus();
        if (stray_rd) drive_ack(1'b0, 1'b1, 32'hFEEDFACE);
        #1;
        chk_all_zero(tag);
    endtask

    initial begin
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all_zero("reset_exit");

        xfer("wr_nostall", 1'b1, 12'h004, 32'hDEADBEEF, 4'b1111, 0, 0,
             32'h0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0, 2, 1);
        idle_cycle("idle1", 1'b0);
        xfer("rd_stall3", 1'b0, 12'h008, 32'h0, 4'b1111, 3, 1,
             32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0, 32'h12345678, 6, 4);
        idle_cycle("idle2", 1'b0);
        xfer("wr_partial", 1'b1, 12'h01C, 32'hA5A5A5A5, 4'b0101, 0, 0,
             32'h0, 1'b0, 1'b0, 32'h00FF00FF, 1'b0, 32'h0, 2, 1);
        xfer("wr_stall2", 1'b1, 12'h018, 32'h0BADCAFE, 4'b1000, 2, 0,
             32'h0, 1'b0, 1'b0, 32'hFF000000, 1'b0, 32'h0, 4, 3);
        idle_cycle("idle3", 1'b0);
        xfer("err_range", 1'b0, 12'h020, 32'h0, 4'b1111, 0, 0,
             32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1, 0);
        xfer("err_align", 1'b1, 12'h002, 32'h11111111, 4'b1111, 0, 0,
             32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1, 0);
        xfer("wr_buserr", 1'b1, 12'h010, 32'h76543210, 4'b0011, 0, 2,
             32'h0, 1'b1, 1'b0, 32'h0000FFFF, 1'b1, 32'h0, 4, 1);
        xfer("rd_buserr", 1'b0, 12'h00C, 32'h0, 4'b1111, 0, 0,
             32'hFFFF0000, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF0000, 2, 1);
        xfer("wr_nostrb", 1'b1, 12'h014, 32'h13579BDF, 4'b0000, 0, 0,
             32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2, 1);
        idle_cycle("idle4", 1'b0);
        xfer("rd_timeout", 1'b0, 12'h000, 32'h0, 4'b1111, 0, 0,
             32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h0, 18, 1);
        idle_cycle("late_ack", 1'b1);
        xfer("rd_after_tmo", 1'b0, 12'h018, 32'h0, 4'b1111, 0, 0,
             32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 1'b0, 32'hCAFEF00D, 2, 1);
        idle_cycle("idle5", 1'b0);

        // Abandon a read in WAIT with an asynchronous reset.
        @(negedge clk);
        clear_bus();
        psel = 1'b1;
        penable = 1'b0;
        pwrite = 1'b0;
        paddr = 12'h004;
        pwdata = '0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        chk("rst_req_seen", {31'b0, bus_req}, 32'h1);
        @(negedge clk);
        #1;
        chk("rst_in_wait", {31'b0, bus_req | pready}, 32'h0);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        psel = 1'b0;
        penable = 1'b0;
        rst = 1'b0;
        #1;
        chk_all_zero("rst_release");

        xfer("b2b_wr", 1'b1, 12'h00C, 32'h11223344, 4'b1111, 0, 0,
             32'h0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0, 2, 1);
        xfer("b2b_rd", 1'b0, 12'h00C, 32'h0, 4'b1111, 0, 0,
             32'h55667788, 1'b0, 1'b0, 32'h0, 1'b0, 32'h55667788, 2, 1);
        idle_cycle("idle_end", 1'b0);
        chk("sb_drained", sb.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
